// File: rtl/relu_backward.sv
// relu_backward: gradient gating for the backward pass of a ReLU activation.
// The forward side records one mask bit per pre-activation (1 = x >= 0) into a
// small FIFO. The backward side pops one mask bit per upstream gradient and
// passes the gradient or zero through a single output register.
// Optional build macro RELU_BWD_LEAKY_EN: masked-off gradients become
// grad_data >>> LEAK_SHIFT instead of zero.
module relu_backward #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fwd_valid,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_ready,
    input  logic                  grad_valid,
    input  logic [DATA_WIDTH-1:0] grad_data,
    output logic                  grad_ready,
    output logic                  dx_valid,
    output logic [DATA_WIDTH-1:0] dx_data,
    input  logic                  dx_ready,
    output logic [ADDR_WIDTH:0]   mask_count
);

    localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  mask_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  dx_valid_q, dx_valid_d;
    logic [DATA_WIDTH-1:0] dx_data_q, dx_data_d;

    logic                  push;
    logic                  pop;
    logic                  mask_bit;
    logic [DATA_WIDTH-1:0] neg_grad;
    logic [DATA_WIDTH-1:0] gated;

    // Readiness comes from registered state only: no full-pop or empty-push bypass.
    assign fwd_ready  = (count_q != FullCount);
    assign grad_ready = (count_q != '0) && (!dx_valid_q || dx_ready);

    assign push     = fwd_valid && fwd_ready;
    assign pop      = grad_valid && grad_ready;
    assign mask_bit = mask_mem_q[rd_ptr_q];

`ifdef RELU_BWD_LEAKY_EN
    // Leaky slope 2^-LEAK_SHIFT in the negative region.
    assign neg_grad = $signed(grad_data) >>> LEAK_SHIFT;
`else
    assign neg_grad = '0;
`endif

    assign gated = mask_bit ? grad_data : neg_grad;

    assign dx_valid   = dx_valid_q;
    assign dx_data    = dx_data_q;
    assign mask_count = count_q;

    // Next-state for pointers, occupancy and the output register; flush wins over traffic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dx_valid_d = dx_valid_q;
        dx_data_d  = dx_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            dx_valid_d = 1'b1;
            dx_data_d  = gated;
        end else if (dx_ready) begin
            dx_valid_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            dx_valid_d = 1'b0;
            dx_data_d  = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dx_valid_q <= 1'b0;
            dx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dx_valid_q <= dx_valid_d;
            dx_data_q  <= dx_data_d;
        end
    end

    // Mask storage; contents beyond the occupancy are don't-care, so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mask_mem_q[wr_ptr_q] <= ~fwd_data[DATA_WIDTH-1];
        end
    end

    // Parameter sanity: depth matches the address width, and the leak shift keeps a sign bit.
    assert property (@(posedge clk) (DEPTH == (1 << ADDR_WIDTH)) && (LEAK_SHIFT < DATA_WIDTH));

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward with hand-computed expectations.
module tb_relu_backward;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
    logic          fwd_ready;
    logic          grad_valid;
    logic [DW-1:0] grad_data;
    logic          grad_ready;
    logic          dx_valid;
    logic [DW-1:0] dx_data;
    logic          dx_ready;
    logic [AW:0]   mask_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output for a masked-off gradient.
`ifdef RELU_BWD_LEAKY_EN
    localparam logic [DW-1:0] NegG0200 = 16'h0040;
    localparam logic [DW-1:0] NegG0080 = 16'h0010;
    localparam logic [DW-1:0] NegGff80 = 16'hfff0;
    localparam logic [DW-1:0] NegG0400 = 16'h0080;
`else
    localparam logic [DW-1:0] NegG0200 = 16'h0000;
    localparam logic [DW-1:0] NegG0080 = 16'h0000;
    localparam logic [DW-1:0] NegGff80 = 16'h0000;
    localparam logic [DW-1:0] NegG0400 = 16'h0000;
`endif

    relu_backward #(
        .DATA_WIDTH(DW),
        .DEPTH     (64),
        .ADDR_WIDTH(AW),
        .LEAK_SHIFT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data),
        .fwd_ready (fwd_ready),
        .grad_valid(grad_valid),
        .grad_data (grad_data),
        .grad_ready(grad_ready),
        .dx_valid  (dx_valid),
        .dx_data   (dx_data),
        .dx_ready  (dx_ready),
        .mask_count(mask_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fwd_valid = 1'b1;
        fwd_data  = d;
        step();
        fwd_valid = 1'b0;
    endtask

    task automatic pop_grad(input logic [DW-1:0] g);
        grad_valid = 1'b1;
        grad_data  = g;
        step();
        grad_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        fwd_valid  = 1'b0;
        fwd_data   = '0;
        grad_valid = 1'b0;
        grad_data  = '0;
        dx_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset / idle state
        check_eq("rst_dx_valid", 32'(dx_valid), 32'h0);
        check_eq("rst_dx_data", 32'(dx_data), 32'h0);
        check_eq("rst_count", 32'(mask_count), 32'h0);
        check_eq("rst_fwd_ready", 32'(fwd_ready), 32'h1);
        check_eq("rst_grad_ready", 32'(grad_ready), 32'h0);

        // Basic gating: masks 1, 0, 1 (zero counts as positive)
        dx_ready = 1'b1;
        push_word(16'h0005);
        push_word(16'hfff0);
        push_word(16'h0000);
        check_eq("basic_count3", 32'(mask_count), 32'd3);
        check_eq("basic_grad_ready", 32'(grad_ready), 32'h1);
        grad_valid = 1'b1;
        grad_data  = 16'h0100;
        step();
        check_eq("basic_dx0_valid", 32'(dx_valid), 32'h1);
        check_eq("basic_dx0", 32'(dx_data), 32'h0100);
        check_eq("basic_count2", 32'(mask_count), 32'd2);
        grad_data = 16'h0200;
        step();
        check_eq("basic_dx1", 32'(dx_data), 32'(NegG0200));
        check_eq("basic_count1", 32'(mask_count), 32'd1);
        grad_data = 16'h0300;
        step();
        check_eq("basic_dx2", 32'(dx_data), 32'h0300);
        check_eq("basic_count0", 32'(mask_count), 32'd0);
        grad_valid = 1'b0;
        step();
        check_eq("basic_drain", 32'(dx_valid), 32'h0);
        check_eq("basic_empty_gready", 32'(grad_ready), 32'h0);

        // Fill to capacity: even entries positive, odd entries negative
        fwd_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            fwd_data = (i % 2 == 1) ? (16'h8000 | 16'(i)) : 16'(i);
            step();
        end
        check_eq("full_count", 32'(mask_count), 32'd64);
        check_eq("full_fwd_ready", 32'(fwd_ready), 32'h0);
        fwd_data = 16'h0001;
        step();
        fwd_valid = 1'b0;
        check_eq("full_65th_dropped", 32'(mask_count), 32'd64);
        pop_grad(16'h1234);
        check_eq("full_pop_fwd_ready", 32'(fwd_ready), 32'h1);
        check_eq("full_pop_count", 32'(mask_count), 32'd63);
        check_eq("full_pop_dx", 32'(dx_data), 32'h1234);
        pop_grad(16'h0200);
        check_eq("full_pop2_dx", 32'(dx_data), 32'(NegG0200));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("full_flush_count", 32'(mask_count), 32'd0);

        // Backpressure: dx held while dx_ready is low
        push_word(16'h0001);
        push_word(16'h0002);
        dx_ready   = 1'b0;
        grad_valid = 1'b1;
        grad_data  = 16'h0100;
        step();
        grad_data = 16'h0999;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_grad_ready", 32'(grad_ready), 32'h0);
            check_eq("bp_dx_valid", 32'(dx_valid), 32'h1);
            check_eq("bp_dx_data", 32'(dx_data), 32'h0100);
            step();
        end
        check_eq("bp_count_held", 32'(mask_count), 32'd1);
        dx_ready = 1'b1;
        #1;
        check_eq("bp_release_gready", 32'(grad_ready), 32'h1);
        step();
        grad_valid = 1'b0;
        check_eq("bp_next_dx", 32'(dx_data), 32'h0999);
        check_eq("bp_next_count", 32'(mask_count), 32'd0);
        step();
        check_eq("bp_drained", 32'(dx_valid), 32'h0);

        // Flush with a push and a pending dx in the same cycle
        for (int i = 0; i < 10; i++) begin
            push_word(16'(i + 1));
        end
        check_eq("fl_count10", 32'(mask_count), 32'd10);
        dx_ready = 1'b0;
        pop_grad(16'h0555);
        check_eq("fl_dx_pending", 32'(dx_valid), 32'h1);
        fwd_valid = 1'b1;
        fwd_data  = 16'h0077;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        fwd_valid = 1'b0;
        check_eq("fl_count0", 32'(mask_count), 32'd0);
        check_eq("fl_dx_valid", 32'(dx_valid), 32'h0);
        check_eq("fl_dx_data", 32'(dx_data), 32'h0);
        check_eq("fl_grad_ready", 32'(grad_ready), 32'h0);
        dx_ready = 1'b1;
        push_word(16'hffff);
        pop_grad(16'h0400);
        check_eq("fl_after_dx", 32'(dx_data), 32'(NegG0400));
        check_eq("fl_after_count", 32'(mask_count), 32'd0);

        // Reset mid-stream discards stored masks and pending dx
        push_word(16'h0001);
        push_word(16'h0002);
        dx_ready = 1'b0;
        pop_grad(16'h0abc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst_count", 32'(mask_count), 32'd0);
        check_eq("mrst_dx_valid", 32'(dx_valid), 32'h0);
        check_eq("mrst_dx_data", 32'(dx_data), 32'h0);
        check_eq("mrst_fwd_ready", 32'(fwd_ready), 32'h1);

        // Negative-region gradients (zero, or shifted in the leaky build)
        dx_ready = 1'b1;
        push_word(16'h8000);
        push_word(16'hff00);
        pop_grad(16'h0080);
        check_eq("neg_dx_pos_grad", 32'(dx_data), 32'(NegG0080));
        pop_grad(16'hff80);
        check_eq("neg_dx_neg_grad", 32'(dx_data), 32'(NegGff80));
        step();
        check_eq("neg_drained", 32'(dx_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
